// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the CPU-to-byte-SRAM bridge: FSM states, timing
// defaults and address helpers.
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam int WAIT_CYCLES_DEF = 1;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;

    // Word accesses are always aligned to the even (low) byte.
    function automatic logic [ADDR_W-1:0] lo_addr(input logic [ADDR_W-1:0] a,
                                                  input logic              byte_acc);
        return byte_acc ? a : {a[ADDR_W-1:1], 1'b0};
    endfunction

    function automatic logic [ADDR_W-1:0] hi_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:1], 1'b1};
    endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// CPU request bus plus byte-wide asynchronous SRAM pins seen by the bridge.
interface mem_bridge_if;
    import mem_bridge_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rd_mem;
    logic              wr_mem;
    logic              byt;
    logic              ready;
    logic              busy;

    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_dout;
    logic [7:0]        sram_din;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    // Bridge side: serves CPU requests and drives the SRAM.
    modport slave (
        input  addr, wdata, rd_mem, wr_mem, byt, sram_din,
        output rdata, ready, busy, sram_addr, sram_dout,
        output sram_ce_n, sram_oe_n, sram_we_n
    );

    // Environment side: CPU requester and SRAM device.
    modport master (
        output addr, wdata, rd_mem, wr_mem, byt, sram_din,
        input  rdata, ready, busy, sram_addr, sram_dout,
        input  sram_ce_n, sram_oe_n, sram_we_n
    );

endinterface

// File: rtl/mem_bridge.sv
// Splits 16-bit CPU reads/writes into one or two byte phases on an 8-bit SRAM,
// each phase held WAIT_CYCLES+1 cycles; all outputs are registered.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input logic         clk,
    input logic         rst_n,
    mem_bridge_if.slave bus
);

    localparam logic [3:0] PHASE_LOAD = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        phase_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_hi_q;
    logic [7:0]        rdata_lo_q;
    logic              byt_q;
    logic              phase_last;

    assign phase_last = (phase_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            phase_cnt     <= 4'd0;
            addr_q        <= '0;
            wdata_hi_q    <= 8'h00;
            rdata_lo_q    <= 8'h00;
            byt_q         <= 1'b0;
            bus.ready     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rdata     <= '0;
            bus.sram_addr <= '0;
            bus.sram_dout <= 8'h00;
            bus.sram_ce_n <= 1'b1;
            bus.sram_oe_n <= 1'b1;
            bus.sram_we_n <= 1'b1;
        end else begin
            bus.ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_mem || bus.rd_mem) begin
                        addr_q        <= lo_addr(bus.addr, bus.byt);
                        wdata_hi_q    <= bus.wdata[15:8];
                        byt_q         <= bus.byt;
                        phase_cnt     <= PHASE_LOAD;
                        bus.busy      <= 1'b1;
                        bus.sram_addr <= lo_addr(bus.addr, bus.byt);
                        bus.sram_dout <= bus.wdata[7:0];
                        bus.sram_ce_n <= 1'b0;
                        // Write has priority when both requests are present.
                        if (bus.wr_mem) begin
                            state         <= WR_LO;
                            bus.sram_oe_n <= 1'b1;
                            bus.sram_we_n <= 1'b0;
                        end else begin
                            state         <= RD_LO;
                            bus.sram_oe_n <= 1'b0;
                            bus.sram_we_n <= 1'b1;
                        end
                    end
                end

                RD_LO, RD_HI: begin
                    if (!phase_last) begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end else if (state == RD_LO && !byt_q) begin
                        rdata_lo_q    <= bus.sram_din;
                        phase_cnt     <= PHASE_LOAD;
                        bus.sram_addr <= hi_addr(addr_q);
                        state         <= RD_HI;
                    end else begin
                        bus.rdata     <= (state == RD_LO) ? {8'h00, bus.sram_din}
                                                          : {bus.sram_din, rdata_lo_q};
                        bus.ready     <= 1'b1;
                        bus.sram_ce_n <= 1'b1;
                        bus.sram_oe_n <= 1'b1;
                        bus.sram_we_n <= 1'b1;
                        state         <= DONE;
                    end
                end

                WR_LO, WR_HI: begin
                    if (!phase_last) begin
                        phase_cnt <= phase_cnt - 4'd1;
                        // Release WE one cycle early so the data is held past the rising edge.
                        if (phase_cnt == 4'd1) begin
                            bus.sram_we_n <= 1'b1;
                        end
                    end else if (state == WR_LO && !byt_q) begin
                        phase_cnt     <= PHASE_LOAD;
                        bus.sram_addr <= hi_addr(addr_q);
                        bus.sram_dout <= wdata_hi_q;
                        bus.sram_we_n <= 1'b0;
                        state         <= WR_HI;
                    end else begin
                        bus.ready     <= 1'b1;
                        bus.sram_ce_n <= 1'b1;
                        bus.sram_oe_n <= 1'b1;
                        bus.sram_we_n <= 1'b1;
                        state         <= DONE;
                    end
                end

                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: directed vector table, reset/back-to-back sequences and
// randomized transactions against a transaction-level memory model.
module tb_mem_bridge;

    localparam int W1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_bridge_if bus1 ();
    mem_bridge_if bus0 ();

    mem_bridge #(.WAIT_CYCLES(W1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mem_bridge #(.WAIT_CYCLES(0))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    // SRAM device model for dut1: writes land at a rising edge with CE and WE low.
    logic [7:0]  mem1 [0:65535];
    logic        poke_en;
    logic [15:0] poke_a;
    logic [7:0]  poke_d;

    always @(posedge clk) begin
        if (poke_en)
            mem1[poke_a] <= poke_d;
        else if (!bus1.sram_ce_n && !bus1.sram_we_n)
            mem1[bus1.sram_addr] <= bus1.sram_dout;
    end

    assign bus1.sram_din = mem1[bus1.sram_addr];
    assign bus0.sram_din = bus0.sram_addr[7:0] ^ 8'h5A;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issue one request on bus1 and observe it until ready (bounded).
    task automatic run_txn(input logic r, input logic w, input logic b,
                           input logic [15:0] a, input logic [15:0] wd,
                           output int lat, output logic [15:0] rd_out,
                           output int oe_cnt, output int we_cnt,
                           output int busy_bad, output logic [15:0] a0);
        logic got;
        @(negedge clk);
        bus1.rd_mem = r;
        bus1.wr_mem = w;
        bus1.byt    = b;
        bus1.addr   = a;
        bus1.wdata  = wd;
        got = 1'b0; lat = 0; rd_out = '0; oe_cnt = 0; we_cnt = 0; busy_bad = 0; a0 = '0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a0 = bus1.sram_addr;
                bus1.addr  = 16'($urandom);
                bus1.wdata = 16'($urandom);
                bus1.byt   = ~b;
            end
            if (!bus1.sram_oe_n) oe_cnt++;
            if (!bus1.sram_we_n) we_cnt++;
            if (!bus1.busy) busy_bad++;
            if (bus1.ready) begin
                got    = 1'b1;
                lat    = k;
                rd_out = bus1.rdata;
                bus1.rd_mem = 1'b0;
                bus1.wr_mem = 1'b0;
            end
        end
        check("ready_seen", 64'(got), 64'd1);
        bus1.rd_mem = 1'b0;
        bus1.wr_mem = 1'b0;
        @(negedge clk);
        check("ready_pulse_busy_clear", {62'd0, bus1.ready, bus1.busy}, 64'd0);
    endtask

    typedef struct {
        logic        rd, wr, byt;
        logic [15:0] addr, wdata;
        logic [15:0] pre_a;
        logic [7:0]  pre_lo, pre_hi;
        logic [15:0] exp_rdata;
        int          exp_lat, exp_oe, exp_we;
        logic [15:0] exp_a0;
        logic [15:0] chk_a;
        logic [7:0]  chk_lo, chk_hi;
    } vec_t;

    vec_t vecs [8];
    logic [7:0] ref_mem [0:31];

    initial begin
        int lat, oe_c, we_c, bb;
        logic [15:0] rd_v, a0;

        poke_en = 1'b0; poke_a = '0; poke_d = '0;
        bus1.rd_mem = 0; bus1.wr_mem = 0; bus1.byt = 0; bus1.addr = 0; bus1.wdata = 0;
        bus0.rd_mem = 0; bus0.wr_mem = 0; bus0.byt = 0; bus0.addr = 0; bus0.wdata = 0;
        rst_n = 1'b0;

        //            rd wr byt addr     wdata    pre_a    lo     hi     rdata    lat oe we a0       chk_a    clo    chi
        vecs[0] = '{1, 0, 1, 16'h0101, 16'h0000, 16'h0101, 8'hA5, 8'h5A, 16'h00A5, 3, 2, 0, 16'h0101, 16'h0101, 8'hA5, 8'h5A};
        vecs[1] = '{0, 1, 0, 16'h0235, 16'hBEEF, 16'h0234, 8'h00, 8'h00, 16'h0000, 5, 0, 2, 16'h0234, 16'h0234, 8'hEF, 8'hBE};
        vecs[2] = '{1, 0, 0, 16'h0020, 16'h0000, 16'h0020, 8'h34, 8'h12, 16'h1234, 5, 4, 0, 16'h0020, 16'h0020, 8'h34, 8'h12};
        vecs[3] = '{1, 1, 1, 16'h0300, 16'h1177, 16'h0300, 8'h00, 8'hEE, 16'h0000, 3, 0, 1, 16'h0300, 16'h0300, 8'h77, 8'hEE};
        vecs[4] = '{1, 0, 0, 16'hFFFE, 16'h0000, 16'hFFFE, 8'hCD, 8'hAB, 16'hABCD, 5, 4, 0, 16'hFFFE, 16'hFFFE, 8'hCD, 8'hAB};
        vecs[5] = '{1, 0, 0, 16'h0021, 16'h0000, 16'h0020, 8'h78, 8'h56, 16'h5678, 5, 4, 0, 16'h0020, 16'h0020, 8'h78, 8'h56};
        vecs[6] = '{0, 1, 1, 16'h0041, 16'h99C3, 16'h0041, 8'h00, 8'hEE, 16'h0000, 3, 0, 1, 16'h0041, 16'h0041, 8'hC3, 8'hEE};
        vecs[7] = '{0, 1, 0, 16'h0051, 16'hA1B2, 16'h0050, 8'h00, 8'h00, 16'h0000, 5, 0, 2, 16'h0050, 16'h0050, 8'hB2, 8'hA1};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {19'd0, bus1.ready, bus1.busy, bus1.rdata, bus1.sram_addr, bus1.sram_dout,
               bus1.sram_ce_n, bus1.sram_oe_n, bus1.sram_we_n},
              {19'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 3'b111});
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            poke(vecs[i].pre_a, vecs[i].pre_lo);
            poke(vecs[i].pre_a + 16'd1, vecs[i].pre_hi);
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].byt, vecs[i].addr, vecs[i].wdata,
                    lat, rd_v, oe_c, we_c, bb, a0);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_oe_cycles", i), 64'(oe_c), 64'(vecs[i].exp_oe));
            check($sformatf("v%0d_we_cycles", i), 64'(we_c), 64'(vecs[i].exp_we));
            check($sformatf("v%0d_first_addr", i), 64'(a0), 64'(vecs[i].exp_a0));
            check($sformatf("v%0d_busy_held", i), 64'(bb), 64'd0);
            if (vecs[i].wr) begin
                check($sformatf("v%0d_mem_lo", i), 64'(mem1[vecs[i].chk_a]), 64'(vecs[i].chk_lo));
                check($sformatf("v%0d_mem_hi", i), 64'(mem1[vecs[i].chk_a + 16'd1]), 64'(vecs[i].chk_hi));
            end else begin
                check($sformatf("v%0d_rdata", i), 64'(rd_v), 64'(vecs[i].exp_rdata));
            end
        end

        // Reset during the high write phase aborts without a ready pulse.
        @(negedge clk);
        bus1.wr_mem = 1'b1; bus1.byt = 1'b0; bus1.addr = 16'h0500; bus1.wdata = 16'h1234;
        repeat (3) @(negedge clk);
        check("abort_in_hi_phase", {47'd0, bus1.sram_addr, bus1.sram_we_n}, {47'd0, 16'h0501, 1'b0});
        rst_n = 1'b0;
        #1;
        check("abort_strobes_idle",
              {59'd0, bus1.ready, bus1.busy, bus1.sram_ce_n, bus1.sram_oe_n, bus1.sram_we_n},
              {59'd0, 5'b00111});
        bus1.wr_mem = 1'b0;
        begin
            int rdy_seen = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (bus1.ready) rdy_seen++;
            end
            rst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (bus1.ready) rdy_seen++;
            end
            check("abort_no_ready", 64'(rdy_seen), 64'd0);
        end
        run_txn(1'b1, 1'b0, 1'b1, 16'h0101, 16'h0000, lat, rd_v, oe_c, we_c, bb, a0);
        check("after_abort_latency", 64'(lat), 64'd3);
        check("after_abort_rdata", 64'(rd_v), 64'h00A5);

        // Back-to-back byte reads with zero wait cycles and the request held.
        begin
            int hits = 0, first = 0, last = -1, gap_bad = 0, data_bad = 0;
            @(negedge clk);
            bus0.rd_mem = 1'b1; bus0.byt = 1'b1; bus0.addr = 16'h0010;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (bus0.ready) begin
                    if (last >= 0 && k - last != 3) gap_bad++;
                    if (hits == 0) first = k;
                    if (bus0.rdata !== 16'h004A) data_bad++;
                    hits++;
                    last = k;
                end
            end
            bus0.rd_mem = 1'b0;
            check("b2b_ready_count", 64'(hits), 64'd4);
            check("b2b_first_ready", 64'(first), 64'd2);
            check("b2b_gap", 64'(gap_bad), 64'd0);
            check("b2b_rdata", 64'(data_bad), 64'd0);
            repeat (3) @(negedge clk);
        end

        // Randomized transactions against a byte-array model of the SRAM window.
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = 8'($urandom);
            poke(16'h0600 + 16'(i), ref_mem[i]);
        end
        for (int t = 0; t < 40; t++) begin
            int op, off, lo_off, exp_lat;
            logic b, r, w;
            logic [15:0] wd, exp_rd;
            op  = $urandom_range(0, 2);
            b   = 1'($urandom_range(0, 1));
            off = $urandom_range(0, 31);
            wd  = 16'($urandom);
            r   = (op != 1);
            w   = (op != 0);
            lo_off  = b ? off : (off & ~1);
            exp_lat = b ? W1 + 2 : 2 * (W1 + 1) + 1;
            exp_rd  = b ? {8'h00, ref_mem[lo_off]} : {ref_mem[lo_off + 1], ref_mem[lo_off]};
            if (w) begin
                ref_mem[lo_off] = wd[7:0];
                if (!b) ref_mem[lo_off + 1] = wd[15:8];
            end
            run_txn(r, w, b, 16'h0600 + 16'(off), wd, lat, rd_v, oe_c, we_c, bb, a0);
            check($sformatf("rnd%0d_latency", t), 64'(lat), 64'(exp_lat));
            check($sformatf("rnd%0d_first_addr", t), 64'(a0), 64'(16'h0600 + 16'(lo_off)));
            check($sformatf("rnd%0d_oe_cycles", t), 64'(oe_c), 64'(w ? 0 : (b ? 1 : 2) * (W1 + 1)));
            check($sformatf("rnd%0d_we_cycles", t), 64'(we_c), 64'(w ? (b ? 1 : 2) * W1 : 0));
            if (!w) check($sformatf("rnd%0d_rdata", t), 64'(rd_v), 64'(exp_rd));
        end
        begin
            int mem_bad = 0;
            for (int i = 0; i < 32; i++)
                if (mem1[16'h0600 + 16'(i)] !== ref_mem[i]) mem_bad++;
            check("rnd_final_memory", 64'(mem_bad), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
